// File: rtl/adder_pkg.sv
// Shared constants for the carry-lookahead adder.
//   CLA_GROUP_W     : bits per first-level lookahead group
//   cla_num_groups(): number of groups for a given operand width
package adder_pkg;

  localparam int CLA_GROUP_W = 4;

  function automatic int cla_num_groups(input int width);
    return width / CLA_GROUP_W;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group.
// Ports:
//   a[3:0], b[3:0] : operand slices
//   c_in           : carry into bit 0 of the group
//   s[3:0]         : sum slice
//   gg, gp         : group generate / group propagate for the next lookahead level
//   c3             : carry into bit 3 (the top group uses it for signed overflow)
module cla_group4
  import adder_pkg::*;
(
  input  logic [CLA_GROUP_W-1:0] a,
  input  logic [CLA_GROUP_W-1:0] b,
  input  logic                   c_in,
  output logic [CLA_GROUP_W-1:0] s,
  output logic                   gg,
  output logic                   gp,
  output logic                   c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  assign g = a & b;
  assign p = a ^ b;

  // Every internal carry is a flat sum of products; no carry feeds another.
  assign c1 = g[0] | (p[0] & c_in);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & c_in);

  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
  assign gp = &p;

  assign s = p ^ {c3, c2, c1, c_in};

endmodule

// File: rtl/cla_adder.sv
// 32-bit (parameterisable) two-level carry-lookahead adder with registered outputs.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset, clears sum and overflow
//   a, b     : two's-complement operands
//   cin      : carry into bit 0
//   sum      : registered (a + b + cin) mod 2^WIDTH, one cycle latency
//   overflow : registered signed-overflow flag of the same addition
module cla_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             overflow
);

  localparam int NG = cla_num_groups(WIDTH);

  if ((WIDTH % CLA_GROUP_W) != 0 || WIDTH < 8) begin : g_width_check
    $error("cla_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [NG:0]      gc;
  logic [WIDTH-1:0] sum_d;
  logic             c_msb;
  logic             ovf_d;
  logic [WIDTH-1:0] sum_q;
  logic             ovf_q;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    logic c3_w;

    cla_group4 u_grp (
      .a    (a[gi*CLA_GROUP_W +: CLA_GROUP_W]),
      .b    (b[gi*CLA_GROUP_W +: CLA_GROUP_W]),
      .c_in (gc[gi]),
      .s    (sum_d[gi*CLA_GROUP_W +: CLA_GROUP_W]),
      .gg   (gg[gi]),
      .gp   (gp[gi]),
      .c3   (c3_w)
    );

    if (gi == NG-1) begin : g_top
      assign c_msb = c3_w;
    end else begin : g_low
      logic c3_unused;
      assign c3_unused = c3_w;
    end
  end

  // Second-level lookahead: each group carry-in is built as an independent
  // sum of products over (GG, GP, cin); the loops unroll into flat terms.
  always_comb begin
    logic acc;
    logic prop;
    gc    = '0;
    gc[0] = cin;
    for (int k = 0; k < NG; k++) begin
      acc  = gg[k];
      prop = gp[k];
      for (int j = k - 1; j >= 0; j--) begin
        acc  = acc | (prop & gg[j]);
        prop = prop & gp[j];
      end
      gc[k+1] = acc | (prop & cin);
    end
  end

  // Carry into the MSB differs from carry out of it exactly on signed overflow.
  assign ovf_d = c_msb ^ gc[NG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end

  assign sum      = sum_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_cla_adder.sv
module tb_cla_adder;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic [31:0] sum;
  logic        overflow;

  int pass_cnt;
  int total_cnt;

  cla_adder #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sum      (sum),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation, let one rising edge capture it, sample 1 ns later.
  task automatic run_vec(input string name, input logic [31:0] va, input logic [31:0] vb,
                         input logic vc, input logic [31:0] exp_s, input logic exp_o);
    a   = va;
    b   = vb;
    cin = vc;
    @(posedge clk);
    #1;
    total_cnt++;
    if (sum !== exp_s || overflow !== exp_o)
      $display("FAIL %s: got sum=%08h ovf=%b, expected sum=%08h ovf=%b",
               name, sum, overflow, exp_s, exp_o);
    else
      pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (sum !== 32'h0 || overflow !== 1'b0)
      $display("FAIL reset_state: got sum=%08h ovf=%b, expected sum=00000000 ovf=0", sum, overflow);
    else
      pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_overflow();
    run_vec("pos_wrap",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b1);
    run_vec("neg_wrap",      32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1);
    run_vec("cin_pos_wrap",  32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b1);
  endtask

  task automatic test_mixed_sign();
    run_vec("mixed_m4_p5",     32'hFFFF_FFFC, 32'h0000_0005, 1'b0, 32'h0000_0001, 1'b0);
    run_vec("mixed_m500_p2000",32'hFFFF_FE0C, 32'h0000_07D0, 1'b0, 32'h0000_05DC, 1'b0);
    run_vec("mixed_cancel",    32'hFFFF_FC19, 32'h0000_03E7, 1'b0, 32'h0000_0000, 1'b0);
  endtask

  task automatic test_same_sign();
    run_vec("same_10_10",    32'h0000_000A, 32'h0000_000A, 1'b0, 32'h0000_0014, 1'b0);
    run_vec("same_m10_m20",  32'hFFFF_FFF6, 32'hFFFF_FFEC, 1'b0, 32'hFFFF_FFE2, 1'b0);
    run_vec("same_165_1000", 32'h0000_00A5, 32'h0000_03E8, 1'b0, 32'h0000_048D, 1'b0);
  endtask

  task automatic test_carry_in();
    run_vec("cin_full_prop", 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0);
    run_vec("cin_all_ones",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0);
    run_vec("cin_group_chain", 32'h0FFF_FFFF, 32'h0000_0000, 1'b1, 32'h1000_0000, 1'b0);
  endtask

  task automatic test_async_reset();
    run_vec("pre_reset", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (sum !== 32'h0 || overflow !== 1'b0)
      $display("FAIL async_reset: got sum=%08h ovf=%b, expected sum=00000000 ovf=0", sum, overflow);
    else
      pass_cnt++;
    a = 32'h7FFF_FFFF; b = 32'h0000_0001; cin = 1'b0;
    @(posedge clk);
    #1;
    total_cnt++;
    if (sum !== 32'h0 || overflow !== 1'b0)
      $display("FAIL reset_hold: got sum=%08h ovf=%b, expected sum=00000000 ovf=0", sum, overflow);
    else
      pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (sum !== 32'h8000_0000 || overflow !== 1'b1)
      $display("FAIL reset_release: got sum=%08h ovf=%b, expected sum=80000000 ovf=1", sum, overflow);
    else
      pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic [32:0] full;
    logic        exp_o;
    int          errs;
    errs = 0;
    for (int i = 0; i < 2000; i++) begin
      ra = $urandom();
      rb = $urandom();
      rc = 1'($urandom_range(0, 1));
      if (i % 8 == 0) rb = ~ra;
      full  = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
      exp_o = (ra[31] == rb[31]) && (full[31] != ra[31]);
      a = ra; b = rb; cin = rc;
      @(posedge clk);
      #1;
      total_cnt++;
      if (sum !== full[31:0] || overflow !== exp_o) begin
        errs++;
        if (errs <= 10)
          $display("FAIL rand_%0d: a=%08h b=%08h cin=%b got sum=%08h ovf=%b, expected sum=%08h ovf=%b",
                   i, ra, rb, rc, sum, overflow, full[31:0], exp_o);
      end else begin
        pass_cnt++;
      end
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_overflow();
    test_mixed_sign();
    test_same_sign();
    test_carry_in();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
